// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
//   Locking round-robin arbiter. N decoupled requesters share one decoupled
//   output. A winner keeps the grant until its burst ends, either on its
//   in_last flag or when MAX_BEATS beats have been transferred. Payload,
//   valid and ready paths are combinational; only the arbitration and lock
//   state is registered.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   in_valid    [N]      per-requester valid
//   in_ready    [N]      per-requester ready (only the selected one can be high)
//   in_bits     [N*W]    payloads, requester i at [i*W +: W]
//   in_last     [N]      per-requester end-of-burst flag
//   out_ready   downstream ready
//   out_valid   downstream valid
//   out_bits    [W]      selected payload
//   out_last    final beat of the current burst (flag or beat cap)
//   out_chosen  [clog2(N)] index of the selected requester
//   busy        high while a burst lock is held (registered)
module rr_burst_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N-1:0]                           in_valid,
    output logic [N-1:0]                           in_ready,
    input  logic [N*W-1:0]                         in_bits,
    input  logic [N-1:0]                           in_last,
    input  logic                                   out_ready,
    output logic                                   out_valid,
    output logic [W-1:0]                           out_bits,
    output logic                                   out_last,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]   out_chosen,
    output logic                                   busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t          st_q, st_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [W-1:0]    bits_arr [N];
    logic [IW-1:0]   cand;
    logic [IW-1:0]   sel;
    logic            cap_hit;
    logic            fire;

    // Unpack the flat payload bus so selection is a plain array index.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign bits_arr[g] = in_bits[g*W +: W];
    end

    // Round-robin candidate: lowest valid index above last_grant, otherwise
    // the lowest valid index overall, otherwise 0.
    always_comb begin
        logic          found_hi;
        logic          found_any;
        logic [IW-1:0] cand_hi;
        logic [IW-1:0] cand_any;
        found_hi  = 1'b0;
        found_any = 1'b0;
        cand_hi   = '0;
        cand_any  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_valid[i] && !found_any) begin
                found_any = 1'b1;
                cand_any  = IW'(i);
            end
            if (in_valid[i] && !found_hi && (i > 32'(last_grant_q))) begin
                found_hi = 1'b1;
                cand_hi  = IW'(i);
            end
        end
        cand = found_hi ? cand_hi : cand_any;
    end

    always_comb begin
        sel = (st_q == ST_LOCKED) ? lock_idx_q : cand;
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = out_ready && (32'(sel) == i);
        end
    end

    // The cap is judged on the beat about to transfer: in IDLE that is the
    // first beat of a burst, in LOCKED it is beat beat_cnt_q + 1.
    always_comb begin
        if (st_q == ST_LOCKED) begin
            cap_hit = ((32'(beat_cnt_q) + 32'd1) == MAX_BEATS);
        end else begin
            cap_hit = (MAX_BEATS == 1);
        end
    end

    always_comb begin
        out_chosen = sel;
        out_bits   = bits_arr[sel];
        out_valid  = in_valid[sel];
        out_last   = in_last[sel] || cap_hit;
        fire       = out_valid && out_ready;
    end

    // Next-state logic. Priority only rotates when a burst completes, so a
    // stalled or starved cycle leaves last_grant untouched.
    always_comb begin
        st_d         = st_q;
        lock_idx_d   = lock_idx_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (st_q)
            ST_IDLE: begin
                if (fire) begin
                    if (out_last) begin
                        last_grant_d = sel;
                    end else begin
                        st_d       = ST_LOCKED;
                        lock_idx_d = sel;
                        beat_cnt_d = CW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (out_last) begin
                        st_d         = ST_IDLE;
                        last_grant_d = lock_idx_q;
                        beat_cnt_d   = '0;
                    end
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= ST_IDLE;
            lock_idx_q   <= '0;
            last_grant_q <= IW'(N - 1);
            beat_cnt_q   <= '0;
        end else begin
            st_q         <= st_d;
            lock_idx_q   <= lock_idx_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign busy = (st_q == ST_LOCKED);

endmodule
